// File: rtl/fpu_wb_arbiter.sv
// FPU register-file write-port arbiter with a pending-write scoreboard.
// Define FPU_WB_FIXED_PRIO_EN to give A fixed priority instead of round-robin.
module fpu_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic                     issue_valid_i,
    input  logic [ADDR_W-1:0]        issue_dest_i,
    input  logic [ADDR_W-1:0]        issue_src1_i,
    input  logic [ADDR_W-1:0]        issue_src2_i,
    output logic                     issue_stall_o,
    input  logic                     a_valid_i,
    input  logic [ADDR_W-1:0]        a_dest_i,
    input  logic [DATA_W-1:0]        a_data_i,
    output logic                     a_ready_o,
    input  logic                     b_valid_i,
    input  logic [ADDR_W-1:0]        b_dest_i,
    input  logic [DATA_W-1:0]        b_data_i,
    output logic                     b_ready_o,
    output logic                     RegWrite_o,
    output logic [ADDR_W-1:0]        WriteRegister_o,
    output logic [DATA_W-1:0]        WriteData_o,
    output logic [(1<<ADDR_W)-1:0]   pending_o
);
    localparam int NREG = 1 << ADDR_W;

    logic              grant_a, grant_b, grant;
    logic [ADDR_W-1:0] g_dest;
    logic [DATA_W-1:0] g_data;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              regwrite_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;

`ifdef FPU_WB_FIXED_PRIO_EN
    assign grant_a = a_valid_i;
`else
    logic last_b_q; // 1 when B holds the most recent grant

    assign grant_a = a_valid_i && (!b_valid_i || last_b_q);

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i)
            last_b_q <= 1'b1;
        else if (grant_a)
            last_b_q <= 1'b0;
        else if (grant_b)
            last_b_q <= 1'b1;
    end
`endif

    assign grant_b = b_valid_i && !grant_a;
    assign grant   = grant_a || grant_b;
    assign g_dest  = grant_a ? a_dest_i : b_dest_i;
    assign g_data  = grant_a ? a_data_i : b_data_i;

    assign a_ready_o     = grant_a;
    assign b_ready_o     = grant_b;
    assign issue_stall_o = issue_valid_i &&
                           (pending_q[issue_src1_i] || pending_q[issue_src2_i] ||
                            pending_q[issue_dest_i]);

    // Set is applied after clear so a same-cycle issue to the granted register wins.
    always_comb begin
        pending_d = pending_q;
        if (grant)
            pending_d[g_dest] = 1'b0;
        if (issue_valid_i && !issue_stall_o)
            pending_d[issue_dest_i] = 1'b1;
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            pending_q  <= '0;
        end else begin
            regwrite_q <= grant;
            pending_q  <= pending_d;
            if (grant) begin
                wreg_q  <= g_dest;
                wdata_q <= g_data;
            end
        end
    end

    assign RegWrite_o      = regwrite_q;
    assign WriteRegister_o = wreg_q;
    assign WriteData_o     = wdata_q;
    assign pending_o       = pending_q;
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed + randomized bench for fpu_wb_arbiter against a scoreboard reference model.
module tb_fpu_wb_arbiter;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        issue_valid;
    logic [4:0]  issue_dest, issue_src1, issue_src2;
    logic        issue_stall;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_dest, b_dest;
    logic [31:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] pending;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // reference model state
    bit          mp[32];
    bit          m_last_b;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    always #5 Clk = ~Clk;

    fpu_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk_i(Clk), .Reset_i(Reset),
        .issue_valid_i(issue_valid), .issue_dest_i(issue_dest),
        .issue_src1_i(issue_src1), .issue_src2_i(issue_src2),
        .issue_stall_o(issue_stall),
        .a_valid_i(a_valid), .a_dest_i(a_dest), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_dest_i(b_dest), .b_data_i(b_data), .b_ready_o(b_ready),
        .RegWrite_o(RegWrite), .WriteRegister_o(WriteRegister), .WriteData_o(WriteData),
        .pending_o(pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mvec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mp[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mp[i] = 1'b0;
        m_last_b = 1'b1;
        m_rw = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_rw", 64'(RegWrite), 64'(m_rw));
        chk("rst_wr", 64'(WriteRegister), 64'(m_wr));
        chk("rst_wd", 64'(WriteData), 64'(m_wd));
        chk("rst_pend", 64'(pending), 64'(mvec()));
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    // One clock: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input logic iv, input logic [4:0] id, input logic [4:0] s1,
                         input logic [4:0] s2, input logic av, input logic [4:0] ad,
                         input logic [31:0] adat, input logic bv, input logic [4:0] bd,
                         input logic [31:0] bdat, output logic ga, output logic gb);
        logic e_stall;
        issue_valid = iv; issue_dest = id; issue_src1 = s1; issue_src2 = s2;
        a_valid = av; a_dest = ad; a_data = adat;
        b_valid = bv; b_dest = bd; b_data = bdat;
        #2;
        e_stall = iv && (mp[s1] || mp[s2] || mp[id]);
`ifdef FPU_WB_FIXED_PRIO_EN
        ga = av;
`else
        ga = (av && bv) ? m_last_b : av;
`endif
        gb = bv && !ga;
        chk("a_ready", 64'(a_ready), 64'(ga));
        chk("b_ready", 64'(b_ready), 64'(gb));
        chk("stall", 64'(issue_stall), 64'(e_stall));
        @(posedge Clk);
        if (ga) begin
            m_rw = 1'b1; m_wr = ad; m_wd = adat; mp[ad] = 1'b0; m_last_b = 1'b0;
        end else if (gb) begin
            m_rw = 1'b1; m_wr = bd; m_wd = bdat; mp[bd] = 1'b0; m_last_b = 1'b1;
        end else begin
            m_rw = 1'b0;
        end
        if (iv && !e_stall) mp[id] = 1'b1;
        #1;
        chk("RegWrite", 64'(RegWrite), 64'(m_rw));
        chk("WriteRegister", 64'(WriteRegister), 64'(m_wr));
        chk("WriteData", 64'(WriteData), 64'(m_wd));
        chk("pending", 64'(pending), 64'(mvec()));
    endtask

    task automatic idle();
        logic ga, gb;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    endtask

    initial begin
        logic ga, gb;
        logic ah, bh;
        logic av, bv, iv;
        logic [4:0] ad, bd, id, s1, s2;
        logic [31:0] adat, bdat;
        logic [3:0] seq;

        Reset = 1'b0; issue_valid = 0; issue_dest = 0; issue_src1 = 0; issue_src2 = 0;
        a_valid = 0; a_dest = 0; a_data = 0; b_valid = 0; b_dest = 0; b_data = 0;
        model_reset();
        #1;
        do_reset();

        // single A write
        cycle(0, 0, 0, 0, 1, 5'd3, 32'h3F800000, 0, 0, 0, ga, gb);
        chk("t1_ready", 64'(ga), 64'(1));
        chk("t1_rw", 64'(RegWrite), 64'(1));
        chk("t1_wr", 64'(WriteRegister), 64'(3));
        chk("t1_wd", 64'(WriteData), 64'(32'h3F800000));
        idle();
        chk("t1_rw_off", 64'(RegWrite), 64'(0));

        // both requesters continuous after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, ga, gb);
            seq[i] = ga;
            chk("rr_rw", 64'(RegWrite), 64'(1));
        end
`ifdef FPU_WB_FIXED_PRIO_EN
        chk("rr_seq", 64'(seq), 64'(4'b1111));
`else
        chk("rr_seq", 64'(seq), 64'(4'b0101));
`endif
        idle();

        // RAW stall on f5 cleared by a B write
        cycle(1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("sb_set5", 64'(pending[5]), 64'(1));
        cycle(1, 5'd6, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("sb_stall", 64'(issue_stall), 64'(1));
        cycle(1, 5'd6, 5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 32'h40000000, ga, gb);
        chk("sb_wr5", 64'(WriteRegister), 64'(5));
        #2 chk("sb_unstall", 64'(issue_stall), 64'(0));
        cycle(1, 5'd6, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("sb_set6", 64'(pending[6]), 64'(1));

        // issue and grant on the same register: set wins
        cycle(1, 5'd7, 5'd0, 5'd0, 1, 5'd7, 32'h7, 0, 0, 0, ga, gb);
        chk("set_wins", 64'(pending[7]), 64'(1));

        // f0 is writable
        cycle(0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 0, ga, gb);
        chk("f0_wr", 64'(WriteRegister), 64'(0));
        chk("f0_wd", 64'(WriteData), 64'(32'hDEADBEEF));

        // async reset between a grant and its write edge
        cycle(1, 5'd9, 5'd0, 5'd0, 1, 5'd9, 32'h99, 0, 0, 0, ga, gb);
        a_valid = 1; a_dest = 5'd4; a_data = 32'h44;
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rw", 64'(RegWrite), 64'(0));
        chk("mid_wr", 64'(WriteRegister), 64'(0));
        chk("mid_pend", 64'(pending), 64'(0));
        #1 Reset = 1'b0;
        cycle(0, 0, 0, 0, 1, 5'd4, 32'h44, 1, 5'd8, 32'h88, ga, gb);
        chk("mid_a_first", 64'(ga), 64'(1));
        chk("mid_wr4", 64'(WriteRegister), 64'(4));

        // randomized traffic; requesters hold until accepted
        ah = 0; bh = 0; av = 0; bv = 0; ad = 0; bd = 0; adat = 0; bdat = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ah) begin
                av = 1'($urandom_range(0, 1)); ad = 5'($urandom_range(0, 7)); adat = $urandom;
            end
            if (!bh) begin
                bv = 1'($urandom_range(0, 1)); bd = 5'($urandom_range(0, 7)); bdat = $urandom;
            end
            iv = 1'($urandom_range(0, 1));
            id = 5'($urandom_range(0, 7));
            s1 = 5'($urandom_range(0, 7));
            s2 = 5'($urandom_range(0, 7));
            cycle(iv, id, s1, s2, av, ad, adat, bv, bd, bdat, ga, gb);
            ah = av && !ga;
            bh = bv && !gb;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fpu_wb_arbiter.md
# fpu_wb_arbiter

Write-port controller for the FPU register file. Shares the file's single synchronous write port between two result producers: the FPU arithmetic unit (A) and the load/move-to-coprocessor path (B). Keeps a 32-entry pending-write scoreboard so the issue stage stalls on RAW/WAW hazards against FPU registers. Sits between the FPU execute/memory stages and the FPU register file's WriteData/WriteRegister/RegWrite inputs.

## Interface
- DATA_W, 32, width of result data
- ADDR_W, 5, register address width (32 registers, f0 writable)

- Clk  in  1  clock, positive edge
- Reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode stage presents an FPU-destination instruction
- issue_dest  in  ADDR_W  destination register of issuing instruction
- issue_src1, issue_src2  in  ADDR_W  source registers of issuing instruction
- issue_stall  out  1  combinational; issue must hold
- a_valid  in  1  FPU result available
- a_dest  in  ADDR_W  FPU result register
- a_data  in  DATA_W  FPU result
- a_ready  out  1  combinational; A accepted this cycle
- b_valid, b_dest, b_data, b_ready  same as A, for load/mtc1 path
- RegWrite  out  1  registered write enable to register file
- WriteRegister  out  ADDR_W  registered write address
- WriteData  out  DATA_W  registered write data
- pending  out  32  registered scoreboard, bit n = write to fn outstanding

## Operation
- Arbitration: at most one grant per cycle. Only A valid -> grant A; only B -> grant B; both -> grant the requester not granted most recently (round-robin pointer `last`). `last` updates only on a grant.
- Handshake: transfer when x_valid && x_ready. Requester holds valid/dest/data stable until ready. x_ready never asserted without x_valid.
- Write stage: on a grant, at the next edge RegWrite<=1, WriteRegister<=granted dest, WriteData<=granted data. No grant -> RegWrite<=0; WriteRegister/WriteData hold.
- Scoreboard: issue accepted when issue_valid && !issue_stall -> pending[issue_dest]<=1 at the edge. Grant of dest d -> pending[d]<=0 at the same edge. Both on same bit in one cycle -> set wins.
- issue_stall = issue_valid && (pending[issue_src1] || pending[issue_src2] || pending[issue_dest]). Uses registered pending only; no same-cycle bypass.
- Grant for a dest whose pending bit is 0 is still written; scoreboard bit stays 0.
- Reset (any time, async): RegWrite=0, WriteRegister=0, WriteData=0, pending=0, `last`=B (A has priority first). In-flight grants are discarded; requesters must re-present.

## Timing
- Combinational: a_ready, b_ready, issue_stall (from inputs and registered state).
- Grant -> RegWrite high exactly 1 cycle later, for 1 cycle per grant; back-to-back grants produce back-to-back writes.
- pending bit clears at the grant edge, i.e. the cycle RegWrite is asserted; a dependent issue unstalls that cycle and reads the register file the cycle after the write edge.
- Throughput: 1 write/cycle. Worst-case wait for a continuously valid requester: 1 cycle.

## Configuration
- FPU_WB_FIXED_PRIO_EN defined: A always wins when both valid; `last` pointer not implemented; B can starve.
- Not defined: round-robin as described.

## Test plan
- Reset then a_valid=1, a_dest=3, a_data=0x3F800000 -> a_ready=1 same cycle; next cycle RegWrite=1, WriteRegister=3, WriteData=0x3F800000; following cycle RegWrite=0.
- a and b both valid continuously for 4 cycles (dests 1,2) -> grants A,B,A,B; RegWrite stays 1 for 4 cycles with WriteRegister 1,2,1,2. With FPU_WB_FIXED_PRIO_EN -> A,A,A,A.
- issue dest=5 accepted -> pending[5]=1; next issue src1=5 -> issue_stall=1 until b writes dest 5; stall drops in the cycle RegWrite=1 for f5.
- Same cycle: issue dest=7 accepted and grant for dest 7 -> pending[7]=1 after the edge (set wins).
- Grant A to f4, assert Reset before next edge -> RegWrite=0, pending=0, WriteRegister=0 immediately; after release A re-presents and wins first.
- Write to f0 (a_dest=0, data 0xDEADBEEF) -> RegWrite=1, WriteRegister=0, WriteData=0xDEADBEEF.
